// File: rtl/mips_isa_pkg.sv
// MIPS-32 opcode constants, encoder request classes and encoder state codes.
// Shared by the instruction encoder and the main-decoder tests.
package mips_isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] REQ_RTYPE = 3'd0;
  localparam logic [2:0] REQ_LW    = 3'd1;
  localparam logic [2:0] REQ_SW    = 3'd2;
  localparam logic [2:0] REQ_BEQ   = 3'd3;
  localparam logic [2:0] REQ_ADDI  = 3'd4;
  localparam logic [2:0] REQ_J     = 3'd5;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_WRITE = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  function automatic logic is_legal_req(input logic [2:0] op);
    return op <= REQ_J;
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Request handshake plus instruction-memory write bus of the instruction encoder.
// The requester uses the master modport, the encoder the slave modport.
interface instr_encoder_if #(
  parameter int ADDR_W = 6
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [4:0]        req_rs;
  logic [4:0]        req_rt;
  logic [4:0]        req_rd;
  logic [5:0]        req_funct;
  logic [15:0]       req_imm;
  logic [ADDR_W-1:0] req_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output req_valid, req_op, req_rs, req_rt, req_rd, req_funct, req_imm, req_target,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  req_valid, req_op, req_rs, req_rt, req_rd, req_funct, req_imm, req_target,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/instr_encoder_enc_word.sv
// Combinational field packer: request class and fields plus the word's own address
// give the 32-bit MIPS instruction; illegal classes pack to a NOP.
module enc_word
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic [2:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       word
);

  localparam int OW = (ADDR_W > 16) ? ADDR_W : 16;

  // Branch offset is relative to the word after the branch, wrapped to 16 bits.
  logic [OW-1:0] off_w;
  logic [15:0]   off16;

  assign off_w = OW'(target) - OW'(addr) - OW'(1);
  assign off16 = off_w[15:0];

  always_comb begin
    word = '0;
    case (op)
      REQ_RTYPE: word = {OP_RTYPE, rs, rt, rd, 5'b00000, funct};
      REQ_LW:    word = {OP_LW, rs, rt, imm};
      REQ_SW:    word = {OP_SW, rs, rt, imm};
      REQ_BEQ:   word = {OP_BEQ, rs, rt, off16};
      REQ_ADDI:  word = {OP_ADDI, rs, rt, imm};
      REQ_J:     word = {OP_J, 26'(target)};
      default:   word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Sequential MIPS-32 instruction encoder: accepts one request, writes its word to the
// next imem address one cycle later. Optional sticky range check: ENC_RANGE_CHECK_EN.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int BASE   = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  instr_encoder_if.slave  bus,
  output logic            full,
  output logic            err
);

  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       enc_w;
  logic              accept;

  enc_word #(.ADDR_W(ADDR_W)) u_enc_word (
    .op     (bus.req_op),
    .rs     (bus.req_rs),
    .rt     (bus.req_rt),
    .rd     (bus.req_rd),
    .funct  (bus.req_funct),
    .imm    (bus.req_imm),
    .target (bus.req_target),
    .addr   (addr_q),
    .word   (enc_w)
  );

  assign bus.req_ready  = (state_q == ST_IDLE) && !clear;
  assign accept         = bus.req_valid && bus.req_ready;
  assign bus.imem_we    = (state_q == ST_WRITE);
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign full           = (state_q == ST_FULL);

  // clear always wins: it rewinds the address and returns to IDLE from any state.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (clear) begin
          addr_d = BASE_ADDR;
        end else if (accept) begin
          wdata_d = enc_w;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (clear) begin
          addr_d  = BASE_ADDR;
          state_d = ST_IDLE;
        end else if (addr_q == LAST_ADDR) begin
          state_d = ST_FULL;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_FULL: begin
        if (clear) begin
          addr_d  = BASE_ADDR;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  localparam int CW = ((ADDR_W + 2) > 17) ? (ADDR_W + 2) : 17;

  logic [CW-1:0] off_chk;
  logic          off_in_range;
  logic          bad_req;
  logic          err_q, err_d;

  // The offset fits 16 bits iff every bit from 15 upward is a copy of the sign.
  assign off_chk      = CW'(bus.req_target) - CW'(addr_q) - CW'(1);
  assign off_in_range = (off_chk[CW-1:15] == '0) || (off_chk[CW-1:15] == '1);
  assign bad_req      = accept &&
                        (!is_legal_req(bus.req_op) || ((bus.req_op == REQ_BEQ) && !off_in_range));

  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if (bad_req) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed steps plus a randomized fill,
// checked against an arithmetic model of the MIPS encoding and address sequence.
module tb_instr_encoder;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic clk;
  logic reset;
  logic clear;
  logic full;
  logic err;

  instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

  instr_encoder #(.ADDR_W(ADDR_W), .BASE(0)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bus),
    .full  (full),
    .err   (err)
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int exp_addr;
  int exp_full;
  int exp_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Encoding built from field weights, independent of any bit concatenation.
  function automatic logic [31:0] modelWord(input int op, input int rs, input int rt, input int rd,
                                            input int funct, input int imm, input int target,
                                            input int addr);
    longint w;
    longint f6 = 64'd1 << 26;
    longint f5s = 64'd1 << 21;
    longint f5t = 64'd1 << 16;
    case (op)
      0:       w = rs * f5s + rt * f5t + rd * 2048 + funct;
      1:       w = 35 * f6 + rs * f5s + rt * f5t + imm;
      2:       w = 43 * f6 + rs * f5s + rt * f5t + imm;
      3:       w = 4 * f6 + rs * f5s + rt * f5t + ((target - addr - 1) & 'hFFFF);
      4:       w = 8 * f6 + rs * f5s + rt * f5t + imm;
      5:       w = 2 * f6 + target;
      default: w = 0;
    endcase
    return 32'(w);
  endfunction

  task automatic waitReady();
    int budget = 8;
    while (bus.req_ready !== 1'b1 && budget > 0) begin
      tick();
      budget--;
    end
    checkOutput("req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  task automatic driveReq(input int op, input int rs, input int rt, input int rd,
                          input int funct, input int imm, input int target);
    bus.req_op     = 3'(op);
    bus.req_rs     = 5'(rs);
    bus.req_rt     = 5'(rt);
    bus.req_rd     = 5'(rd);
    bus.req_funct  = 6'(funct);
    bus.req_imm    = 16'(imm);
    bus.req_target = ADDR_W'(target);
    bus.req_valid  = 1'b1;
  endtask

  task automatic applyStimulus(input int op, input int rs, input int rt, input int rd,
                               input int funct, input int imm, input int target);
    logic [31:0] exp_w;
    exp_w = modelWord(op, rs, rt, rd, funct, imm, target, exp_addr);
    waitReady();
    driveReq(op, rs, rt, rd, funct, imm, target);
    tick();
    bus.req_valid = 1'b0;
    checkOutput("imem_we", 32'(bus.imem_we), 32'd1);
    checkOutput("imem_addr", 32'(bus.imem_addr), 32'(exp_addr));
    checkOutput("imem_wdata", bus.imem_wdata, exp_w);
`ifdef ENC_RANGE_CHECK_EN
    if (op > 5) exp_err = 1;
`endif
    tick();
    if (exp_addr == DEPTH - 1) exp_full = 1;
    else exp_addr++;
    checkOutput("full", 32'(full), 32'(exp_full));
    checkOutput("err", 32'(err), 32'(exp_err));
  endtask

  initial begin
    int op;
    reset = 1'b1;
    clear = 1'b0;
    bus.req_valid = 1'b0;
    driveReq(0, 0, 0, 0, 0, 0, 0);
    bus.req_valid = 1'b0;
    exp_addr = 0;
    exp_full = 0;
    exp_err  = 0;

    #2;
    checkOutput("rst_we", 32'(bus.imem_we), 32'd0);
    checkOutput("rst_wdata", bus.imem_wdata, 32'd0);
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_err", 32'(err), 32'd0);
    #20;
    reset = 1'b0;
    tick();
    checkOutput("rst_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rst_addr", 32'(bus.imem_addr), 32'd0);

    $display("[TB] directed encodings");
    applyStimulus(4, 0, 8, 0, 0, 5, 0);
    checkOutput("addi_word", bus.imem_wdata, 32'h2008_0005);
    applyStimulus(0, 8, 9, 10, 'h20, 0, 0);
    checkOutput("rtype_word", bus.imem_wdata, 32'h0109_5020);
    applyStimulus(1, 3, 4, 0, 0, 'h1234, 0);
    applyStimulus(2, 5, 6, 0, 0, 'hFFF0, 0);
    applyStimulus(3, 1, 2, 0, 0, 0, 2);
    checkOutput("beq_off", 32'(bus.imem_wdata[15:0]), 32'h0000_FFFD);
    applyStimulus(5, 0, 0, 0, 0, 0, 'h10);
    checkOutput("j_word", bus.imem_wdata, 32'h0800_0010);

    $display("[TB] random fill to capacity");
    while (exp_full == 0) begin
      op = int'($urandom_range(0, 7));
      applyStimulus(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                    int'($urandom_range(0, 31)), int'($urandom_range(0, 63)),
                    int'($urandom_range(0, 65535)), int'($urandom_range(0, DEPTH - 1)));
    end
    checkOutput("full_ready", 32'(bus.req_ready), 32'd0);
    tick();
    tick();
    checkOutput("full_hold", 32'(full), 32'd1);
    checkOutput("full_we", 32'(bus.imem_we), 32'd0);

    $display("[TB] clear from FULL");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_addr = 0;
    exp_full = 0;
    exp_err  = 0;
    checkOutput("clr_full", 32'(full), 32'd0);
    checkOutput("clr_err", 32'(err), 32'd0);
    applyStimulus(2, 7, 8, 0, 0, 'h0040, 0);

    $display("[TB] clear with req_valid");
    clear = 1'b1;
    driveReq(4, 1, 1, 0, 0, 1, 0);
    #1;
    checkOutput("clrv_ready", 32'(bus.req_ready), 32'd0);
    tick();
    clear = 1'b0;
    bus.req_valid = 1'b0;
    exp_addr = 0;
    checkOutput("clrv_we", 32'(bus.imem_we), 32'd0);
    tick();
    checkOutput("clrv_we2", 32'(bus.imem_we), 32'd0);
    applyStimulus(1, 2, 3, 0, 0, 'h0008, 0);

    $display("[TB] clear during WRITE");
    waitReady();
    driveReq(4, 9, 9, 0, 0, 'h7FFF, 0);
    tick();
    bus.req_valid = 1'b0;
    checkOutput("clrw_we", 32'(bus.imem_we), 32'd1);
    checkOutput("clrw_addr", 32'(bus.imem_addr), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_addr = 0;
    checkOutput("clrw_we_after", 32'(bus.imem_we), 32'd0);
    checkOutput("clrw_addr_after", 32'(bus.imem_addr), 32'd0);

    $display("[TB] reset during WRITE");
    waitReady();
    driveReq(0, 1, 2, 3, 'h22, 0, 0);
    tick();
    bus.req_valid = 1'b0;
    checkOutput("rstw_we", 32'(bus.imem_we), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("rstw_we_drop", 32'(bus.imem_we), 32'd0);
    checkOutput("rstw_wdata", bus.imem_wdata, 32'd0);
    #3;
    reset = 1'b0;
    exp_addr = 0;
    tick();
    checkOutput("rstw_ready", 32'(bus.req_ready), 32'd1);
    checkOutput("rstw_addr", 32'(bus.imem_addr), 32'd0);

`ifdef ENC_RANGE_CHECK_EN
    $display("[TB] illegal op sets err");
    applyStimulus(7, 1, 2, 3, 4, 5, 6);
    checkOutput("ill_word", bus.imem_wdata, 32'd0);
    tick();
    checkOutput("ill_err_hold", 32'(err), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_err  = 0;
    exp_addr = 0;
    checkOutput("ill_err_clr", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
